// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer between pipeline stages: registered ready toward the
// producer, synchronous flush, and a saturating count of downstream bubble cycles.
module pipe_skid_reg #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [CNT_W-1:0]  bubble_q,  bubble_d;

  logic accept;
  logic drain;

  // in_ready is a pure register decode, so out_ready never reaches it.
  assign in_ready   = !s_valid_q;
  assign out_valid  = m_valid_q;
  assign out_data   = m_data_q;
  assign occupancy  = {1'b0, m_valid_q} + {1'b0, s_valid_q};
  assign bubble_cnt = bubble_q;

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    bubble_d  = bubble_q;

    if (out_ready && !m_valid_q && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + CNT_W'(1);
    end

    if (flush) begin
      m_valid_d = 1'b0;
      m_data_d  = '0;
      s_valid_d = 1'b0;
      s_data_d  = '0;
    end else begin
      unique case ({m_valid_q, s_valid_q})
        2'b00: begin
          if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data;
          end
        end
        2'b10: begin
          if (drain && accept) begin
            m_data_d = in_data;
          end else if (drain) begin
            m_valid_d = 1'b0;
            m_data_d  = '0;
          end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
          end
        end
        2'b11: begin
          if (drain) begin
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
            s_data_d  = '0;
          end
        end
        default: begin
          // Skid without main cannot arise; promote it so order is still kept.
          m_valid_d = 1'b1;
          m_data_d  = s_data_q;
          s_valid_d = 1'b0;
          s_data_d  = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: payload registers are reset too, because out_data must read zero
      // whenever the main entry is empty, including during reset.
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      bubble_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      bubble_q  <= bubble_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus random traffic, scored
// against an in-order queue model of the two-entry stage.
module tb_pipe_skid_reg;

  localparam int DATA_W = 128;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] sb[$];
  logic [CNT_W-1:0]  exp_bub;

  pipe_skid_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .occupancy  (occupancy),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  // Reference: the stage is a FIFO of depth two with a registered ready.
  task automatic model_edge();
    logic do_drain;
    logic do_accept;
    if (out_ready && sb.size() == 0 && exp_bub != {CNT_W{1'b1}}) exp_bub = exp_bub + 1'b1;
    if (flush) begin
      sb.delete();
    end else begin
      do_drain  = out_ready && sb.size() != 0;
      do_accept = in_valid && sb.size() < 2;
      if (do_drain) void'(sb.pop_front());
      if (do_accept) sb.push_back(in_data);
    end
  endtask

  task automatic cycle(input logic v, input logic [DATA_W-1:0] d,
                       input logic r, input logic f);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    sb.delete();
    exp_bub = '0;
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 128'hDEAD; out_ready = 1'b0; flush = 1'b0;
    sb.delete();
    exp_bub = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    n_checks++; if (bubble_cnt !== '0) begin n_fail++; $display("FAIL reset_bubble got=%0d exp=0", bubble_cnt); end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_streaming();
    logic [DATA_W-1:0] d;
    for (int i = 1; i <= 4; i++) begin
      d = DATA_W'(i);
      cycle(1'b1, d, 1'b1, 1'b0);
      n_checks++; if (out_data !== d || out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_data[%0d] got=%0h/%0b exp=%0h/1", i, out_data, out_valid, d); end
      n_checks++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, occupancy); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d] got=%0b exp=1", i, in_ready); end
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL stream_empty got=%0b/%0h exp=0/0", out_valid, out_data); end
  endtask

  task automatic test_stall_fill();
    cycle(1'b1, 128'hA, 1'b0, 1'b0);
    n_checks++; if (out_data !== 128'hA || occupancy !== 2'd1) begin n_fail++; $display("FAIL stall_load got=%0h occ=%0d exp=a occ=1", out_data, occupancy); end
    cycle(1'b1, 128'hB, 1'b0, 1'b0);
    n_checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_full occ=%0d rdy=%0b exp occ=2 rdy=0", occupancy, in_ready); end
    n_checks++; if (out_data !== 128'hA) begin n_fail++; $display("FAIL stall_head got=%0h exp=a", out_data); end
    cycle(1'b1, 128'hC, 1'b0, 1'b0);
    n_checks++; if (occupancy !== 2'd2 || out_data !== 128'hA) begin n_fail++; $display("FAIL stall_hold occ=%0d data=%0h exp occ=2 data=a", occupancy, out_data); end
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (out_data !== 128'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_drain1 data=%0h occ=%0d rdy=%0b exp b/1/1", out_data, occupancy, in_ready); end
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL stall_drain2 v=%0b data=%0h occ=%0d exp 0/0/0", out_valid, out_data, occupancy); end
  endtask

  task automatic test_flush();
    cycle(1'b1, 128'hA, 1'b0, 1'b0);
    cycle(1'b1, 128'hB, 1'b0, 1'b0);
    cycle(1'b1, 128'hC, 1'b0, 1'b1);
    n_checks++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL flush_full_out v=%0b data=%0h exp 0/0", out_valid, out_data); end
    n_checks++; if (occupancy !== 2'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full_state occ=%0d rdy=%0b exp 0/1", occupancy, in_ready); end
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_c v=%0b data=%0h exp 0", out_valid, out_data); end
    // Same-cycle accept into a half-full stage must also be discarded.
    cycle(1'b1, 128'hA, 1'b0, 1'b0);
    cycle(1'b1, 128'hD, 1'b1, 1'b1);
    n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== '0) begin n_fail++; $display("FAIL flush_accept v=%0b occ=%0d data=%0h exp 0/0/0", out_valid, occupancy, out_data); end
  endtask

  task automatic test_bubble_sat();
    int exp_c;
    @(negedge clk);
    async_reset();
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      exp_c = (k < 15) ? k : 15;
      n_checks++; if (bubble_cnt !== CNT_W'(exp_c)) begin n_fail++; $display("FAIL bubble_sat[%0d] got=%0d exp=%0d", k, bubble_cnt, exp_c); end
    end
    cycle(1'b1, 128'h7, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (bubble_cnt !== 4'd15) begin n_fail++; $display("FAIL bubble_hold got=%0d exp=15", bubble_cnt); end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 128'h11, 1'b0, 1'b0);
    cycle(1'b1, 128'h22, 1'b0, 1'b0);
    n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL areset_prefill occ=%0d exp=2", occupancy); end
    #2;
    rst = 1'b1;
    sb.delete();
    exp_bub = '0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL areset_out v=%0b data=%0h exp 0/0", out_valid, out_data); end
    n_checks++; if (bubble_cnt !== '0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_state bub=%0d occ=%0d rdy=%0b exp 0/0/1", bubble_cnt, occupancy, in_ready); end
    rst = 1'b0;
    cycle(1'b1, 128'h5, 1'b1, 1'b0);
    n_checks++; if (out_data !== 128'h5 || out_valid !== 1'b1 || occupancy !== 2'd1) begin n_fail++; $display("FAIL areset_first data=%0h v=%0b occ=%0d exp 5/1/1", out_data, out_valid, occupancy); end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp_d;
    for (int i = 0; i < 400; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      cycle(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
      exp_d = (sb.size() != 0) ? sb[0] : '0;
      n_checks++; if (out_valid !== (sb.size() != 0) || out_data !== exp_d) begin n_fail++; $display("FAIL rand_out[%0d] v=%0b data=%0h exp v=%0b data=%0h", i, out_valid, out_data, sb.size() != 0, exp_d); end
      n_checks++; if (occupancy !== 2'(sb.size()) || in_ready !== (sb.size() < 2)) begin n_fail++; $display("FAIL rand_state[%0d] occ=%0d rdy=%0b exp occ=%0d", i, occupancy, in_ready, sb.size()); end
      n_checks++; if (bubble_cnt !== exp_bub) begin n_fail++; $display("FAIL rand_bubble[%0d] got=%0d exp=%0d", i, bubble_cnt, exp_bub); end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_fill();
    test_flush();
    test_bubble_sat();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 128, stage payload width (pc, rs1, rs2, imm packed).
REQ-002 SHALL have parameter CNT_W, default 16, bubble counter width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream payload valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  upstream payload.
REQ-008 SHALL have port flush  input  1  synchronous kill of all held entries (jump/branch taken).
REQ-009 SHALL have port out_valid  output  1  downstream payload valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts; low = stall.
REQ-011 SHALL have port out_data  output  DATA_W  downstream payload.
REQ-012 SHALL have port occupancy  output  2  entries held (0, 1, 2).
REQ-013 SHALL have port bubble_cnt  output  CNT_W  saturating count of bubble cycles.

Function
REQ-014 SHALL hold two entries: main M (drives out_valid/out_data) and skid S; each has valid bit and DATA_W payload.
REQ-015 SHALL drive in_ready = !S.valid, from register state only (no combinational path from out_ready).
REQ-016 SHALL drive out_valid = M.valid and out_data = M.data; out_data SHALL be all zeros whenever M.valid=0.
REQ-017 SHALL define accept = in_valid & in_ready, drain = out_valid & out_ready.
REQ-018 SHALL, when flush=1, next cycle clear M and S valid bits and payloads to zero, discarding any same-cycle accept; flush has priority over all other events.
REQ-019 SHALL, without flush, state transitions (M,S as valid flags):
- empty (0,0): accept -> M<=in_data; else stay.
- one (1,0): drain&accept -> M<=in_data; drain only -> empty, M.data<=0; accept only -> S<=in_data; neither -> hold.
- full (1,1): in_ready=0; drain -> M<=S.data, S cleared to 0; else hold both.
REQ-020 SHALL preserve order: payloads leave in acceptance order; no payload duplicated or lost except by flush.
REQ-021 SHALL give latency 1 cycle: payload accepted at edge N is visible on out_data after edge N when stage was empty or draining.
REQ-022 SHALL sustain one transfer per cycle when out_ready held high.
REQ-023 SHALL drive occupancy = M.valid + S.valid.
REQ-024 SHALL increment bubble_cnt by 1 each cycle with out_ready=1 and out_valid=0, saturating at all-ones (no wrap).
REQ-025 SHALL not count flush cycles specially; post-flush empty cycles counted per REQ-024.
REQ-026 SHALL ignore in_data when accept=0.

Reset
REQ-027 SHALL, on rst assertion, immediately clear M, S (valid and data) and bubble_cnt to zero, independent of clk.
REQ-028 SHALL, during reset, drive out_valid=0, out_data=0, in_ready=1, occupancy=0, bubble_cnt=0.
REQ-029 SHALL, on reset mid-operation with entries held, discard them; first accept after release behaves as from empty.

Verification
REQ-030 Streaming: out_ready=1, in_valid=1, in_data=1,2,3,4 on successive cycles -> out_data 1,2,3,4 one cycle later each, occupancy=1, in_ready always 1.
REQ-031 Stall fill: M holds 0xA, out_ready=0, accept 0xB -> occupancy=2, in_ready=0; next in_data 0xC not accepted; out_ready=1 -> out 0xA then 0xB then empty.
REQ-032 Flush on full: M=0xA, S=0xB, flush=1 with in_valid=1 in_data=0xC -> next cycle out_valid=0, out_data=0, occupancy=0, in_ready=1, 0xC never emitted.
REQ-033 Bubble saturation: CNT_W=4, out_ready=1, in_valid=0 for 20 cycles -> bubble_cnt 1..15 then stays 15.
REQ-034 Async reset: occupancy=2, assert rst between edges -> out_valid=0, bubble_cnt=0 before next edge; release, accept 0x5 -> out_data=0x5 one cycle later.
